bop_round_judge: RTL and testbench

//  Parametrised successor to the game's per-command input checker. Judges one round per accepted command:
//  NUM_INPUTS key lines, programmable response window, edge-detected presses, hit/miss/timeout pulses,

---
 rtl/bop_round_judge.sv | 166 ++++++++++++++++
 tb/tb_bop_round_judge.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bop_round_judge.sv
// Per-command reaction judge: accepts a command, watches the key lines for one response window,
// and reports hit/miss/timeout while keeping a saturating per-game score.
module bop_round_judge #(
  parameter int unsigned NUM_INPUTS = 3,
  parameter int unsigned CMD_W      = 2,
  parameter int unsigned WINDOW_W   = 26,
  parameter int unsigned SCORE_W    = 8,
  parameter int unsigned STRICT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_INPUTS-1:0] keys,
  input  logic                  cmd_valid,
  input  logic [CMD_W-1:0]      cmd,
  input  logic [WINDOW_W-1:0]   window_len,
  output logic                  ready,
  output logic                  hit,
  output logic                  miss,
  output logic                  timeout,
  output logic                  cmd_err,
  output logic                  game_over,
  output logic [SCORE_W-1:0]    score,
  output logic [2:0]            state
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StWait    = 3'd1;
  localparam logic [2:0] StRound   = 3'd2;
  localparam logic [2:0] StRelease = 3'd3;
  localparam logic [2:0] StOver    = 3'd4;

  logic [2:0]            state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  hit_q, hit_d;
  logic                  miss_q, miss_d;
  logic                  timeout_q, timeout_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  game_over_q, game_over_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [WINDOW_W-1:0]   timer_q, timer_d;
  logic [CMD_W-1:0]      cmd_q, cmd_d;
  logic                  start_q;
  logic [NUM_INPUTS-1:0] keys_q;

  logic [NUM_INPUTS-1:0] press;
  logic [NUM_INPUTS-1:0] cmd_oh;
  logic                  cmd_ok;
  logic                  keys_clear;
  logic                  good_press;

  assign press      = keys & ~keys_q;
  assign cmd_oh     = NUM_INPUTS'(1) << cmd_q;
  assign cmd_ok     = 32'(cmd) < NUM_INPUTS;
  assign keys_clear = (keys == '0);
  // Strict mode also rejects a correct press while any other key is still held.
  assign good_press = (press != '0) && (press == cmd_oh) && ((STRICT == 0) || (keys == cmd_oh));

  always_comb begin
    state_d   = state_q;
    ready_d   = 1'b0;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    timeout_d = 1'b0;
    cmd_err_d = 1'b0;
    score_d   = score_q;
    timer_d   = timer_q;
    cmd_d     = cmd_q;
    case (state_q)
      StIdle: begin
        if (start && !start_q) begin
          state_d = StWait;
          score_d = '0;
        end
      end
      StWait: begin
        ready_d = keys_clear;
        if (!start) begin
          state_d = StIdle;
          ready_d = 1'b0;
        end else if (cmd_valid && ready_q) begin
          if (cmd_ok) begin
            state_d = StRound;
            ready_d = 1'b0;
            cmd_d   = cmd;
            timer_d = (window_len == '0) ? WINDOW_W'(1) : window_len;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      StRound: begin
        if (!start) begin
          state_d = StIdle;
        end else if (good_press) begin
          hit_d   = 1'b1;
          score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
          state_d = StRelease;
        end else if (press != '0) begin
          miss_d  = 1'b1;
          state_d = StOver;
        end else if (timer_q == WINDOW_W'(1)) begin
          timeout_d = 1'b1;
          state_d   = StOver;
        end else begin
          timer_d = timer_q - WINDOW_W'(1);
        end
      end
      StRelease: begin
        if (!start) begin
          state_d = StIdle;
        end else if (keys_clear) begin
          state_d = StWait;
        end
      end
      StOver: begin
        if (!start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    game_over_d = (state_d == StOver);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      game_over_q <= 1'b0;
      score_q     <= '0;
      timer_q     <= '0;
      cmd_q       <= '0;
      // Levels held through reset must not look like fresh edges afterwards.
      start_q     <= 1'b1;
      keys_q      <= '1;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      timeout_q   <= timeout_d;
      cmd_err_q   <= cmd_err_d;
      game_over_q <= game_over_d;
      score_q     <= score_d;
      timer_q     <= timer_d;
      cmd_q       <= cmd_d;
      start_q     <= start;
      keys_q      <= keys;
    end
  end

  assign ready     = ready_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign timeout   = timeout_q;
  assign cmd_err   = cmd_err_q;
  assign game_over = game_over_q;
  assign score     = score_q;
  assign state     = state_q;

endmodule

// File: tb/tb_bop_round_judge.sv
// Directed bench for bop_round_judge (3 keys, strict, 2-bit score to reach saturation quickly).
module tb_bop_round_judge;

  logic        clk = 1'b0;
  logic        reset, start, cmd_valid;
  logic [2:0]  keys;
  logic [1:0]  cmd;
  logic [25:0] window_len;
  logic        ready, hit, miss, timeout, cmd_err, game_over;
  logic [1:0]  score;
  logic [2:0]  state;

  int n_chk  = 0;
  int n_fail = 0;

  bop_round_judge #(
    .NUM_INPUTS(3),
    .CMD_W     (2),
    .WINDOW_W  (26),
    .SCORE_W   (2),
    .STRICT    (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .keys      (keys),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .window_len(window_len),
    .ready     (ready),
    .hit       (hit),
    .miss      (miss),
    .timeout   (timeout),
    .cmd_err   (cmd_err),
    .game_over (game_over),
    .score     (score),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expects WAIT with ready=1; plays one correct round on key c.
  task automatic do_hit(input logic [1:0] c, input logic [1:0] exp_score);
    logic [2:0] oh;
    oh = 3'b001 << c;
    cmd = c; window_len = 26'd8; cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    chk("loop_round", 32'(state), 32'd2);
    keys = oh;
    step(1);
    chk("loop_hit", 32'(hit), 32'd1);
    chk("loop_score", 32'(score), 32'(exp_score));
    keys = 3'b000;
    step(2);
    chk("loop_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    // T1: keys held through reset never count as presses
    reset = 1'b1; start = 1'b0; keys = 3'b111; cmd_valid = 1'b0; cmd = 2'd0; window_len = '0;
    step(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    reset = 1'b0;
    step(1);
    keys = 3'b000;
    step(1);
    chk("t1_no_miss", 32'(miss), 32'd0);
    start = 1'b1;
    step(1);
    chk("t1_wait", 32'(state), 32'd1);
    step(1);
    chk("t1_ready", 32'(ready), 32'd1);
    chk("t1_score", 32'(score), 32'd0);

    // T2: hit on the 4th round cycle
    cmd = 2'd1; window_len = 26'd10; cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    chk("t2_round", 32'(state), 32'd2);
    chk("t2_ready_low", 32'(ready), 32'd0);
    step(3);
    chk("t2_no_early", 32'({hit, miss, timeout}), 32'd0);
    keys = 3'b010;
    step(1);
    chk("t2_hit", 32'(hit), 32'd1);
    chk("t2_score", 32'(score), 32'd1);
    chk("t2_release", 32'(state), 32'd3);
    step(1);
    chk("t2_hit_once", 32'(hit), 32'd0);
    keys = 3'b000;
    step(1);
    chk("t2_wait", 32'(state), 32'd1);
    chk("t2_ready_lag", 32'(ready), 32'd0);
    step(1);
    chk("t2_ready", 32'(ready), 32'd1);

    // T3: window of 5 expires with no press
    cmd = 2'd0; window_len = 26'd5; cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    step(4);
    chk("t3_not_yet", 32'({timeout, state}), 32'({1'b0, 3'd2}));
    step(1);
    chk("t3_timeout", 32'(timeout), 32'd1);
    chk("t3_over", 32'(state), 32'd4);
    chk("t3_game_over", 32'(game_over), 32'd1);
    step(1);
    chk("t3_pulse_once", 32'(timeout), 32'd0);
    start = 1'b0;
    step(1);
    chk("t3_idle", 32'(state), 32'd0);
    chk("t3_go_clear", 32'(game_over), 32'd0);
    chk("t3_score_held", 32'(score), 32'd1);

    // T4: strict miss on simultaneous correct+wrong press
    start = 1'b1;
    step(1);
    chk("t4_wait", 32'(state), 32'd1);
    chk("t4_score_clr", 32'(score), 32'd0);
    keys = 3'b100;
    step(1);
    cmd = 2'd0; window_len = 26'd10; cmd_valid = 1'b1;
    step(1);
    chk("t4_rejected", 32'({ready, state}), 32'({1'b0, 3'd1}));
    keys = 3'b000;
    step(1);
    chk("t4_still_wait", 32'(state), 32'd1);
    chk("t4_ready", 32'(ready), 32'd1);
    step(1);
    cmd_valid = 1'b0;
    chk("t4_round", 32'(state), 32'd2);
    keys = 3'b101;
    step(1);
    chk("t4_miss", 32'({hit, miss}), 32'b01);
    chk("t4_over", 32'(state), 32'd4);
    keys = 3'b000; start = 1'b0;
    step(1);
    chk("t4_idle", 32'(state), 32'd0);

    // T5: bad command index, then zero-length window acts as one cycle
    start = 1'b1;
    step(2);
    chk("t5_ready", 32'(ready), 32'd1);
    cmd = 2'd3; cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    chk("t5_cmd_err", 32'(cmd_err), 32'd1);
    chk("t5_stay_wait", 32'(state), 32'd1);
    step(1);
    chk("t5_err_once", 32'(cmd_err), 32'd0);
    cmd = 2'd2; window_len = 26'd0; cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    chk("t5_round", 32'(state), 32'd2);
    keys = 3'b100;
    step(1);
    chk("t5_hit", 32'({hit, timeout}), 32'b10);
    chk("t5_score", 32'(score), 32'd1);
    keys = 3'b000;
    step(2);
    chk("t5_ready2", 32'(ready), 32'd1);

    // T6: score saturates at 3, then abort mid-round
    do_hit(2'd0, 2'd2);
    do_hit(2'd1, 2'd3);
    do_hit(2'd2, 2'd3);
    do_hit(2'd0, 2'd3);
    cmd = 2'd0; window_len = 26'd10; cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    chk("t6_round", 32'(state), 32'd2);
    start = 1'b0; keys = 3'b001;
    step(1);
    chk("t6_idle", 32'(state), 32'd0);
    chk("t6_no_pulse", 32'({hit, miss, timeout, cmd_err}), 32'd0);
    chk("t6_score_held", 32'(score), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
